// File: rtl/apb_master_bridge.sv
// apb_master_bridge: APB3 requester turning one core load/store into one APB transfer,
// with base-window decode and a bounded PREADY wait.
module apb_master_bridge #(
    parameter int          ADDR_W    = 5,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          TIMEOUT   = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [31:0]       PWDATA,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] T_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, ACCESS = 3'd2, RESP = 3'd3, DERR = 3'd4;
    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic          w_hit;
    logic          w_abort;
    assign w_hit     = req_addr[31:ADDR_W] == BASE_ADDR[31:ADDR_W];
    assign req_ready = r_state == IDLE;
    assign busy      = r_state != IDLE;
    // PREADY wins over an expiring counter in the same cycle
    assign w_abort   = (r_state == ACCESS) && !PREADY && (TIMEOUT != 0) && (r_cnt == T_LAST);
    always_comb begin
        w_next = (r_state == IDLE)   ? (req_valid ? (w_hit ? SETUP : DERR) : IDLE) :
                 (r_state == SETUP)  ? ACCESS :
                 (r_state == ACCESS) ? ((PREADY || w_abort) ? RESP : ACCESS) :
                                       IDLE;
    end
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (r_state == ACCESS && !PREADY) ? ((&r_cnt) ? r_cnt : r_cnt + 1'b1) : '0;
            PSEL      <= (w_next == SETUP) || (w_next == ACCESS);
            PENABLE   <= w_next == ACCESS;
            rsp_valid <= (w_next == RESP) || (w_next == DERR);
            rsp_err   <= (w_next == DERR) || w_abort;
            rsp_rdata <= (r_state == ACCESS && PREADY && !PWRITE) ? PRDATA : '0;
            if (r_state == IDLE && req_valid && w_hit) begin
                PADDR  <= req_addr[ADDR_W-1:0];
                PWRITE <= req_write;
                PWDATA <= req_wdata;
            end
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed checks of the APB requester with TIMEOUT=4.
module tb_apb_master_bridge;
    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, busy, PSEL, PENABLE, PWRITE;
    logic [31:0] rsp_rdata, PWDATA;
    logic [4:0]  PADDR;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    int          n_chk = 0, n_fail = 0;
    int          cyc;

    apb_master_bridge #(.ADDR_W(5), .BASE_ADDR(32'h4000_0000), .TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst req_ready", req_ready, 1);
        chk("rst psel", PSEL, 0);
        chk("rst penable", PENABLE, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst pwdata", PWDATA, 0);
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        step();
        // zero-wait write
        chk("w1 ready", req_ready, 1);
        issue(1'b1, 32'h4000_0000, 32'h3);
        chk("w1 T1 psel", PSEL, 1);
        chk("w1 T1 penable", PENABLE, 0);
        chk("w1 T1 paddr", PADDR, 5'h00);
        chk("w1 T1 pwrite", PWRITE, 1);
        chk("w1 T1 pwdata", PWDATA, 32'h3);
        chk("w1 T1 ready", req_ready, 0);
        step();
        chk("w1 T2 psel", PSEL, 1);
        chk("w1 T2 penable", PENABLE, 1);
        PREADY = 1'b1;
        step();
        PREADY = 1'b0;
        chk("w1 T3 rsp_valid", rsp_valid, 1);
        chk("w1 T3 rsp_err", rsp_err, 0);
        chk("w1 T3 rsp_rdata", rsp_rdata, 0);
        chk("w1 T3 psel", PSEL, 0);
        step();
        chk("w1 T4 rsp_valid", rsp_valid, 0);
        chk("w1 T4 ready", req_ready, 1);
        // read with two wait cycles
        PRDATA = 32'h18;
        issue(1'b0, 32'h4000_0008, 32'h0);
        chk("r2 T1 paddr", PADDR, 5'h08);
        chk("r2 T1 pwrite", PWRITE, 0);
        step();
        chk("r2 T2 penable", PENABLE, 1);
        step();
        chk("r2 T3 penable", PENABLE, 1);
        chk("r2 T3 rsp_valid", rsp_valid, 0);
        step();
        PREADY = 1'b1;
        chk("r2 T4 paddr", PADDR, 5'h08);
        chk("r2 T4 penable", PENABLE, 1);
        step();
        PREADY = 1'b0;
        chk("r2 T5 rsp_valid", rsp_valid, 1);
        chk("r2 T5 rsp_rdata", rsp_rdata, 32'h18);
        chk("r2 T5 rsp_err", rsp_err, 0);
        step();
        chk("r2 T6 rsp_valid", rsp_valid, 0);
        // timeout abort after four ACCESS cycles
        PRDATA = 32'hDEAD_BEEF;
        issue(1'b0, 32'h4000_0004, 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("to psel", PSEL, 1);
            chk("to penable", PENABLE, 1);
            step();
        end
        chk("to psel dropped", PSEL, 0);
        chk("to rsp_valid", rsp_valid, 1);
        chk("to rsp_err", rsp_err, 1);
        chk("to rsp_rdata", rsp_rdata, 0);
        step();
        chk("to after rsp_valid", rsp_valid, 0);
        chk("to after ready", req_ready, 1);
        PRDATA = 32'h77;
        issue(1'b0, 32'h4000_000C, 32'h0);
        step();
        PREADY = 1'b1;
        step();
        PREADY = 1'b0;
        chk("post-to rsp_valid", rsp_valid, 1);
        chk("post-to rsp_err", rsp_err, 0);
        chk("post-to rsp_rdata", rsp_rdata, 32'h77);
        step();
        // PREADY on the last allowed ACCESS cycle still succeeds
        PRDATA = 32'h99;
        issue(1'b0, 32'h4000_0004, 32'h0);
        step();
        step();
        step();
        step();
        PREADY = 1'b1;
        chk("edge penable", PENABLE, 1);
        step();
        PREADY = 1'b0;
        chk("edge rsp_valid", rsp_valid, 1);
        chk("edge rsp_err", rsp_err, 0);
        chk("edge rsp_rdata", rsp_rdata, 32'h99);
        step();
        // decode error: PADDR keeps 0x04
        issue(1'b0, 32'h5000_0008, 32'h0);
        chk("derr psel", PSEL, 0);
        chk("derr rsp_valid", rsp_valid, 1);
        chk("derr rsp_err", rsp_err, 1);
        chk("derr rsp_rdata", rsp_rdata, 0);
        chk("derr paddr", PADDR, 5'h04);
        chk("derr busy", busy, 1);
        step();
        chk("derr T2 rsp_valid", rsp_valid, 0);
        chk("derr T2 ready", req_ready, 1);
        chk("derr T2 psel", PSEL, 0);
        // back-to-back writes with req_valid held
        PREADY = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 32'h4000_000C;
        req_wdata = 32'h41;
        step();
        req_wdata = 32'h42;
        chk("b2b T1 pwdata", PWDATA, 32'h41);
        chk("b2b T1 ready", req_ready, 0);
        step();
        step();
        chk("b2b T3 rsp_valid", rsp_valid, 1);
        step();
        chk("b2b T4 ready", req_ready, 1);
        chk("b2b T4 rsp_valid", rsp_valid, 0);
        step();
        req_valid = 1'b0;
        chk("b2b T5 psel", PSEL, 1);
        chk("b2b T5 penable", PENABLE, 0);
        chk("b2b T5 pwdata", PWDATA, 32'h42);
        chk("b2b T5 paddr", PADDR, 5'h0C);
        step();
        step();
        chk("b2b T7 rsp_valid", rsp_valid, 1);
        chk("b2b T7 rsp_err", rsp_err, 0);
        step();
        PREADY = 1'b0;
        // reset during ACCESS
        issue(1'b1, 32'h4000_0010, 32'hAA);
        step();
        chk("rstmid penable", PENABLE, 1);
        #2 PRESETn = 1'b0;
        #1;
        chk("rstmid psel", PSEL, 0);
        chk("rstmid penable off", PENABLE, 0);
        chk("rstmid busy", busy, 0);
        chk("rstmid rsp_valid", rsp_valid, 0);
        chk("rstmid ready", req_ready, 1);
        chk("rstmid paddr", PADDR, 0);
        step();
        chk("rstmid held rsp_valid", rsp_valid, 0);
        PRESETn = 1'b1;
        step();
        chk("post-rst ready", req_ready, 1);
        issue(1'b1, 32'h4000_0014, 32'h55);
        chk("post-rst paddr", PADDR, 5'h14);
        chk("post-rst pwdata", PWDATA, 32'h55);
        PREADY = 1'b1;
        cyc = 0;
        while (!rsp_valid && cyc < 8) begin
            step();
            cyc++;
        end
        PREADY = 1'b0;
        chk("post-rst rsp_valid", rsp_valid, 1);
        chk("post-rst latency", cyc, 2);
        chk("post-rst rsp_err", rsp_err, 0);
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
